ps2_scan_parser: RTL and testbench

PS2_SCAN_PARSER -- requirements
Module: ps2_scan_parser

---
 rtl/ps2_pkg.sv | 14 +
 rtl/ps2_event_fifo.sv | 41 ++++
 rtl/ps2_scan_parser.sv | 85 ++++++++
 tb/tb_ps2_scan_parser.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 scan-code constants, parser state encoding and key-event record.
package ps2_pkg;
    localparam logic [7:0] CODE_EXT    = 8'hE0;
    localparam logic [7:0] CODE_BRK    = 8'hF0;
    localparam logic [7:0] CODE_LSHIFT = 8'h12;
    localparam logic [7:0] CODE_RSHIFT = 8'h59;
    localparam logic [7:0] CODE_CAPS   = 8'h58;
    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} ps2_state_e;
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;
endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: key-event FIFO with a registered show-ahead head (new entries appear one cycle after push).
module ps2_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, rd_nxt;
    logic do_push, do_pop;
    assign empty   = wr_ptr == rd_ptr;
    assign full    = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rd_nxt  = rd_ptr + {{AW{1'b0}}, do_pop};
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    // The head only sees entries present before this edge, so a push shows up a cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            wr_ptr   <= wr_ptr + {{AW{1'b0}}, do_push};
            rd_ptr   <= rd_nxt;
            rd_valid <= wr_ptr != rd_nxt;
            rd_data  <= mem[rd_nxt[AW-1:0]];
        end
    end
endmodule

// File: rtl/ps2_scan_parser.sv
// ps2_scan_parser: turns PS/2 set-2 scan bytes into make/break key events, tracks shift/caps state.
module ps2_scan_parser import ps2_pkg::*; #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic       shift_held,
    output logic       caps_lock,
    output logic       overflow,
    output logic       err,
    input  logic       status_clr
);
    ps2_state_e state, state_nxt;
    ps2_event_t ev_in, head;
    logic emit, set_err, is_prefix, fifo_full, fifo_empty, pop, push_drop;
    logic lshift, rshift;
    always_comb begin
        is_prefix = scan_code == CODE_EXT || scan_code == CODE_BRK;
        ev_in     = '{ext: state == EXT || state == EXT_BRK, brk: state == BRK || state == EXT_BRK, code: scan_code};
        emit      = 1'b0;
        set_err   = 1'b0;
        state_nxt = state;
        if (scan_valid) begin
            if (scan_code == 8'h00 || scan_code == 8'hFF) begin
                set_err   = 1'b1;
                state_nxt = IDLE;
            end else if (state == IDLE || state == EXT) begin
                if (scan_code == CODE_BRK) state_nxt = state == EXT ? EXT_BRK : BRK;
                else if (scan_code == CODE_EXT) state_nxt = EXT;
                else begin
                    emit      = 1'b1;
                    state_nxt = IDLE;
                end
            end else begin
                set_err   = is_prefix;
                emit      = ~is_prefix;
                state_nxt = IDLE;
            end
        end
    end
    assign pop       = ev_valid & ev_ready & ~fifo_empty;
    assign push_drop = emit & fifo_full & ~pop;
    ps2_event_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(ps2_event_t))) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (emit),
        .wr_data  (ev_in),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .rd_valid (ev_valid),
        .rd_data  (head)
    );
    assign ev_code    = head.code;
    assign ev_ext     = head.ext;
    assign ev_break   = head.brk;
    assign shift_held = lshift | rshift;
    // Modifier state follows the parsed stream even when the FIFO drops the event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            lshift    <= 1'b0;
            rshift    <= 1'b0;
            caps_lock <= 1'b0;
            overflow  <= 1'b0;
            err       <= 1'b0;
        end else begin
            state    <= state_nxt;
            overflow <= push_drop | (overflow & ~status_clr);
            err      <= set_err | (err & ~status_clr);
            if (emit && !ev_in.ext) begin
                if (ev_in.code == CODE_LSHIFT) lshift <= ~ev_in.brk;
                if (ev_in.code == CODE_RSHIFT) rshift <= ~ev_in.brk;
                if (ev_in.code == CODE_CAPS && !ev_in.brk) caps_lock <= ~caps_lock;
            end
        end
    end
endmodule

// File: tb/tb_ps2_scan_parser.sv
// tb_ps2_scan_parser: directed and randomized checks of the scan parser against a queue-based event model.
module tb_ps2_scan_parser;
    localparam int DEPTH = 4;
    logic clk = 1'b0, reset = 1'b0, scan_valid = 1'b0, ev_ready = 1'b0, status_clr = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic ev_valid, ev_ext, ev_break, shift_held, caps_lock, overflow, err;
    logic [7:0] ev_code;
    int n_tests = 0, n_fail = 0;
    bit chk_on = 1'b0;
    logic [9:0] q[$];
    logic [9:0] m_head;
    bit m_valid, p_ext, p_brk, m_lsh, m_rsh, m_caps, m_ovf, m_err;
    ps2_scan_parser #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_code    (ev_code),
        .ev_ext     (ev_ext),
        .ev_break   (ev_break),
        .shift_held (shift_held),
        .caps_lock  (caps_lock),
        .overflow   (overflow),
        .err        (err),
        .status_clr (status_clr)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask
    task automatic model_reset();
        q.delete();
        m_valid = 0; m_head = '0; p_ext = 0; p_brk = 0;
        m_lsh = 0; m_rsh = 0; m_caps = 0; m_ovf = 0; m_err = 0;
    endtask
    // One clock edge of the reference: prefixes are remembered as two flags, the FIFO is a queue.
    task automatic model_edge();
        bit nv, new_err, new_ovf;
        logic [9:0] nh;
        new_err = 0;
        new_ovf = 0;
        if (m_valid && ev_ready) void'(q.pop_front());
        nv = q.size() > 0;
        nh = nv ? q[0] : m_head;
        if (scan_valid) begin
            if (scan_code == 8'h00 || scan_code == 8'hFF) begin
                new_err = 1; p_ext = 0; p_brk = 0;
            end else if (scan_code == 8'hE0 || scan_code == 8'hF0) begin
                if (p_brk) begin
                    new_err = 1; p_ext = 0; p_brk = 0;
                end else if (scan_code == 8'hE0) p_ext = 1;
                else p_brk = 1;
            end else begin
                if (q.size() < DEPTH) q.push_back({p_ext, p_brk, scan_code});
                else new_ovf = 1;
                if (!p_ext) begin
                    if (scan_code == 8'h12) m_lsh = !p_brk;
                    if (scan_code == 8'h59) m_rsh = !p_brk;
                    if (scan_code == 8'h58 && !p_brk) m_caps = !m_caps;
                end
                p_ext = 0; p_brk = 0;
            end
        end
        m_err = new_err || (m_err && !status_clr);
        m_ovf = new_ovf || (m_ovf && !status_clr);
        m_valid = nv;
        m_head = nh;
    endtask
    always @(negedge clk) begin
        if (chk_on) begin
            chk("ev_valid", 32'(ev_valid), 32'(m_valid));
            if (m_valid) chk("ev_head", 32'({ev_ext, ev_break, ev_code}), 32'(m_head));
            if (reset) chk("reset_head", 32'({ev_ext, ev_break, ev_code}), 32'h0);
            chk("shift_held", 32'(shift_held), 32'(m_lsh | m_rsh));
            chk("caps_lock", 32'(caps_lock), 32'(m_caps));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("err", 32'(err), 32'(m_err));
        end
    end
    task automatic tick();
        @(posedge clk);
        if (!reset) model_edge();
        @(negedge clk);
        #1;
    endtask
    task automatic send(input logic [7:0] b);
        scan_valid = 1'b1;
        scan_code = b;
        tick();
        scan_valid = 1'b0;
    endtask
    task automatic expect_ev(input string nm, input bit v, input logic [9:0] e);
        chk({nm, "_valid"}, 32'(ev_valid), 32'(v));
        if (v) chk(nm, 32'({ev_ext, ev_break, ev_code}), 32'(e));
    endtask
    task automatic pop_one();
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
    endtask
    task automatic pulse_reset();
        reset = 1'b1;
        model_reset();
        tick();
        chk("rst_outs", 32'({ev_valid, ev_code, ev_ext, ev_break, shift_held, caps_lock, overflow, err}), 32'h0);
        reset = 1'b0;
    endtask
    logic [7:0] picks [8] = '{8'hE0, 8'hF0, 8'h12, 8'h59, 8'h58, 8'h00, 8'hFF, 8'h1C};
    initial begin
        #1;
        chk_on = 1'b1;
        pulse_reset();
        tick();
        send(8'h1C); expect_ev("make_lat1", 0, 10'h000);
        tick();      expect_ev("make_1c", 1, 10'h01C);
        pop_one();   expect_ev("make_pop", 0, 10'h000);
        send(8'hF0); send(8'h1C); expect_ev("brk_lat1", 0, 10'h000);
        tick();      expect_ev("brk_1c", 1, 10'h11C);
        pop_one();
        send(8'hE0); send(8'h75); tick(); expect_ev("ext_75", 1, 10'h275); pop_one();
        send(8'hE0); send(8'hF0); send(8'h75); tick(); expect_ev("extbrk_75", 1, 10'h375); pop_one();
        send(8'hE0); send(8'hE0); send(8'h75); tick(); expect_ev("ee_75", 1, 10'h275);
        pop_one();   expect_ev("ee_single", 0, 10'h000);
        ev_ready = 1'b1;
        send(8'h12); chk("shift_make", 32'(shift_held), 32'h1);
        send(8'h1C); chk("shift_thru", 32'(shift_held), 32'h1);
        send(8'hF0); send(8'h12); chk("shift_brk", 32'(shift_held), 32'h0);
        send(8'h58); chk("caps_on", 32'(caps_lock), 32'h1);
        send(8'hF0); send(8'h58); chk("caps_brk", 32'(caps_lock), 32'h1);
        send(8'h58); chk("caps_off", 32'(caps_lock), 32'h0);
        tick(); tick();
        ev_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(8'h15 + 8'(i));
        tick();
        chk("ovf_set", 32'(overflow), 32'h1);
        expect_ev("full_head", 1, 10'h015);
        ev_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick();
            expect_ev("drain", 1, 10'h015 + 10'(i));
        end
        tick();
        expect_ev("drained", 0, 10'h000);
        ev_ready = 1'b0;
        status_clr = 1'b1; tick(); status_clr = 1'b0;
        chk("ovf_clr", 32'(overflow), 32'h0);
        send(8'hF0); send(8'hE0); chk("err_prefix", 32'(err), 32'h1);
        send(8'h00); tick(); expect_ev("err_noev", 0, 10'h000);
        status_clr = 1'b1; tick(); status_clr = 1'b0;
        chk("err_clr", 32'(err), 32'h0);
        send(8'h1C); tick(); expect_ev("idle_after_err", 1, 10'h01C); pop_one();
        send(8'hE0);
        pulse_reset();
        send(8'h75); tick(); expect_ev("after_rst", 1, 10'h075); pop_one();
        for (int i = 0; i < 4000; i++) begin
            scan_valid = $urandom_range(0, 1) == 1;
            scan_code = ($urandom_range(0, 2) == 0) ? 8'($urandom) : picks[$urandom_range(0, 7)];
            ev_ready = ((i / 400) % 2 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            status_clr = $urandom_range(0, 31) == 0;
            if ($urandom_range(0, 499) == 0) pulse_reset();
            tick();
        end
        scan_valid = 1'b0;
        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
